// File: rtl/decode_queue_pkg.sv
// Shared types for the decoupled decode stage: opcode enum, the halt encoding,
// the decoded bundle layout and the immediate-format helpers.
package decode_queue_pkg;

    // Datapath width the stored bundle is laid out for; the queue's XLEN must match.
    localparam int DQ_XLEN = 32;

    localparam logic [31:0] HALT_INSN = 32'hFFFF_FFFF;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_SYSTEM = 7'b1110011
    } dq_opcode_t;

    typedef struct packed {
        logic [DQ_XLEN-1:0] pc;
        logic [31:0]        instr;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [DQ_XLEN-1:0] imm;
        logic               wen;
        logic               dren;
        logic               dwen;
        logic               branch;
        logic               jump;
        logic               illegal;
        logic               halt;
    } dq_bundle_t;

    function automatic logic [DQ_XLEN-1:0] imm_i(input logic [31:0] ins);
        return {{(DQ_XLEN-12){ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [DQ_XLEN-1:0] imm_s(input logic [31:0] ins);
        return {{(DQ_XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic [DQ_XLEN-1:0] imm_b(input logic [31:0] ins);
        return {{(DQ_XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [DQ_XLEN-1:0] imm_j(input logic [31:0] ins);
        return {{(DQ_XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    function automatic logic [DQ_XLEN-1:0] imm_u(input logic [31:0] ins);
        return DQ_XLEN'($signed({ins[31:12], 12'h000}));
    endfunction

endpackage

// File: rtl/dq_decoder.sv
// Purely combinational instruction decoder: raw instruction and PC in,
// fully populated control bundle out.
module dq_decoder
    import decode_queue_pkg::*;
(
    input  logic [31:0]        instr_i,
    input  logic [DQ_XLEN-1:0] pc_i,
    output dq_bundle_t         bundle_o
);

    // Field extraction plus per-opcode control flags and immediate selection.
    always_comb begin
        bundle_o       = '0;
        bundle_o.pc    = pc_i;
        bundle_o.instr = instr_i;
        bundle_o.rd    = instr_i[11:7];
        bundle_o.rs1   = instr_i[19:15];
        bundle_o.rs2   = instr_i[24:20];
        if (instr_i == HALT_INSN) begin
            // All-ones would otherwise fall into the illegal bucket.
            bundle_o.halt = 1'b1;
        end else begin
            case (instr_i[6:0])
                OPC_LOAD: begin
                    bundle_o.dren = 1'b1;
                    bundle_o.wen  = 1'b1;
                    bundle_o.imm  = imm_i(instr_i);
                end
                OPC_STORE: begin
                    bundle_o.dwen = 1'b1;
                    bundle_o.imm  = imm_s(instr_i);
                end
                OPC_BRANCH: begin
                    bundle_o.branch = 1'b1;
                    bundle_o.imm    = imm_b(instr_i);
                end
                OPC_JAL: begin
                    bundle_o.jump = 1'b1;
                    bundle_o.wen  = 1'b1;
                    bundle_o.imm  = imm_j(instr_i);
                end
                OPC_JALR: begin
                    bundle_o.jump = 1'b1;
                    bundle_o.wen  = 1'b1;
                    bundle_o.imm  = imm_i(instr_i);
                end
                OPC_OPIMM: begin
                    bundle_o.wen = 1'b1;
                    bundle_o.imm = imm_i(instr_i);
                end
                OPC_OP: begin
                    bundle_o.wen = 1'b1;
                end
                OPC_LUI, OPC_AUIPC: begin
                    bundle_o.wen = 1'b1;
                    bundle_o.imm = imm_u(instr_i);
                end
                OPC_SYSTEM: begin
                    bundle_o.illegal = 1'b0;
                end
                default: begin
                    bundle_o.illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/decode_queue.sv
// Decoupled decode stage: decodes at enqueue, buffers DEPTH bundles and hands
// them to execute in order, with flush, occupancy and a sticky halt.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = DQ_XLEN
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_instr,
    output dq_opcode_t                 out_opcode,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [XLEN-1:0]            out_imm,
    output logic                       out_wen,
    output logic                       out_dren,
    output logic                       out_dwen,
    output logic                       out_branch,
    output logic                       out_jump,
    output logic                       out_illegal,
    output logic                       out_halt,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       halted
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    dq_bundle_t mem_q [DEPTH];
    ptr_t       head_q, head_d;
    ptr_t       tail_q, tail_d;
    cnt_t       count_q, count_d;
    logic       halt_pending_q, halt_pending_d;
    logic       halted_q, halted_d;

    dq_bundle_t dec_s;
    dq_bundle_t head_s;
    dq_bundle_t head_vis_s;
    logic       full_s;
    logic       enq_s;
    logic       deq_s;

    dq_decoder u_decoder (
        .instr_i  (in_instr),
        .pc_i     (in_pc),
        .bundle_o (dec_s)
    );

    assign full_s    = (count_q == cnt_t'(DEPTH));
    assign in_ready  = !full_s && !halt_pending_q && !halted_q && !flush;
    assign out_valid = (count_q != cnt_t'(0));
    assign enq_s     = in_valid && in_ready;
    assign deq_s     = out_valid && out_ready;
    assign head_s    = mem_q[head_q];

    // Pointer, occupancy and halt bookkeeping; flush wins over both handshakes.
    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        halt_pending_d = halt_pending_q;
        if (deq_s && head_s.halt) begin
            halted_d = 1'b1;
        end else begin
            halted_d = halted_q;
        end
        if (flush) begin
            head_d         = ptr_t'(0);
            tail_d         = ptr_t'(0);
            count_d        = cnt_t'(0);
            halt_pending_d = 1'b0;
        end else begin
            if (enq_s) begin
                tail_d = tail_q + ptr_t'(1);
            end else begin
                tail_d = tail_q;
            end
            if (deq_s) begin
                head_d = head_q + ptr_t'(1);
            end else begin
                head_d = head_q;
            end
            case ({enq_s, deq_s})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
            if (enq_s && dec_s.halt) begin
                halt_pending_d = 1'b1;
            end else begin
                halt_pending_d = halt_pending_q;
            end
        end
    end

    // State registers and bundle storage, with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q         <= ptr_t'(0);
            tail_q         <= ptr_t'(0);
            count_q        <= cnt_t'(0);
            halt_pending_q <= 1'b0;
            halted_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            halt_pending_q <= halt_pending_d;
            halted_q       <= halted_d;
            if (enq_s) begin
                mem_q[tail_q] <= dec_s;
            end
        end
    end

    // Head fields read as zero whenever nothing valid is presented.
    assign head_vis_s  = out_valid ? head_s : '0;
    assign out_pc      = head_vis_s.pc;
    assign out_instr   = head_vis_s.instr;
    assign out_opcode  = dq_opcode_t'(head_vis_s.instr[6:0]);
    assign out_rd      = head_vis_s.rd;
    assign out_rs1     = head_vis_s.rs1;
    assign out_rs2     = head_vis_s.rs2;
    assign out_imm     = head_vis_s.imm;
    assign out_wen     = head_vis_s.wen;
    assign out_dren    = head_vis_s.dren;
    assign out_dwen    = head_vis_s.dwen;
    assign out_branch  = head_vis_s.branch;
    assign out_jump    = head_vis_s.jump;
    assign out_illegal = head_vis_s.illegal;
    assign out_halt    = head_vis_s.halt;
    assign count       = count_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'h0;
    logic [31:0] in_pc = 32'h0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_instr, out_imm;
    dq_opcode_t  out_opcode;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic        out_wen, out_dren, out_dwen, out_branch, out_jump, out_illegal, out_halt;
    logic [2:0]  count;
    logic        halted;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [6:0]  flags; // wen dren dwen branch jump illegal halt
    } exp_t;

    exp_t mq[$];
    bit   m_hp = 1'b0;
    bit   m_halted = 1'b0;

    decode_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_wen(out_wen), .out_dren(out_dren), .out_dwen(out_dwen),
        .out_branch(out_branch), .out_jump(out_jump), .out_illegal(out_illegal),
        .out_halt(out_halt), .count(count), .halted(halted)
    );

    always #5 CLK = ~CLK;

    // Reference decode computed with integer arithmetic on the immediate layouts.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        int   si;
        si      = $signed(ins);
        e.pc    = pc;
        e.instr = ins;
        e.rd    = ins[11:7];
        e.rs1   = ins[19:15];
        e.rs2   = ins[24:20];
        e.imm   = 32'h0;
        e.flags = 7'b0;
        if (ins == 32'hFFFF_FFFF) begin
            e.flags = 7'b0000001;
        end else begin
            case (ins[6:0])
                7'b0000011: begin e.flags = 7'b1100000; e.imm = si >>> 20; end
                7'b0100011: begin e.flags = 7'b0010000; e.imm = (si >>> 25) * 32 + int'(ins[11:7]); end
                7'b1100011: begin
                    e.flags = 7'b0001000;
                    e.imm = (si >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
                end
                7'b1101111: begin
                    e.flags = 7'b1000100;
                    e.imm = (si >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
                end
                7'b1100111: begin e.flags = 7'b1000100; e.imm = si >>> 20; end
                7'b0010011: begin e.flags = 7'b1000000; e.imm = si >>> 20; end
                7'b0110011: begin e.flags = 7'b1000000; end
                7'b0110111, 7'b0010111: begin e.flags = 7'b1000000; e.imm = ins & 32'hFFFF_F000; end
                7'b1110011: begin e.flags = 7'b0000000; end
                default:    begin e.flags = 7'b0000010; end
            endcase
        end
        return e;
    endfunction

    function automatic bit m_in_ready();
        return (mq.size() < DEPTH) && !m_hp && !m_halted && !flush;
    endfunction

    // Advance the reference model by one edge using the currently driven inputs, then clock.
    task automatic tick();
        bit enq, deq;
        enq = in_valid && m_in_ready();
        deq = (mq.size() != 0) && out_ready;
        if (RST) begin
            mq.delete();
            m_hp = 1'b0;
            m_halted = 1'b0;
        end else begin
            if (deq && mq[0].flags[0]) m_halted = 1'b1;
            if (flush) begin
                mq.delete();
                m_hp = 1'b0;
            end else begin
                if (deq) void'(mq.pop_front());
                if (enq) begin
                    mq.push_back(ref_decode(in_instr, in_pc));
                    if (in_instr == 32'hFFFF_FFFF) m_hp = 1'b1;
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                         input bit rdy, input bit fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drive(1'b1, 32'h0010_0093, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        RST = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b want 0", halted); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h0010_0093, 32'(i * 4), 1'b0, 1'b0);
            if (i == 4) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %0b want 0", in_ready); end
                checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", count); end
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'(i * 4)) begin
                errors++; $display("FAIL drain_pc[%0d] got v=%0b pc=%h want v=1 pc=%h", i, out_valid, out_pc, 32'(i * 4));
            end
            tick();
        end
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_empty got count=%0d v=%0b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_decode();
        logic [31:0] ins [3];
        ins[0] = 32'hFFC1_0093;
        ins[1] = 32'hFE00_0EE3;
        ins[2] = 32'h0000_007F;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ins[i], 32'h40 + 32'(i * 4), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (out_wen !== 1'b1 || out_rd !== 5'd1 || out_rs1 !== 5'd2 || out_imm !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL dec_addi got wen=%0b rd=%0d rs1=%0d imm=%h want 1/1/2/fffffffc", out_wen, out_rd, out_rs1, out_imm);
        end
        tick();
        checks++; if (out_branch !== 1'b1 || out_wen !== 1'b0 || out_imm !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL dec_beq got br=%0b wen=%0b imm=%h want 1/0/fffffffc", out_branch, out_wen, out_imm);
        end
        tick();
        checks++; if (out_illegal !== 1'b1 || out_wen !== 1'b0 || out_halt !== 1'b0) begin
            errors++; $display("FAIL dec_illegal got ill=%0b wen=%0b halt=%0b want 1/0/0", out_illegal, out_wen, out_halt);
        end
        tick();
    endtask

    task automatic test_throughput();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h0000_0033 | (32'(i) << 7), 32'h1000 + 32'(i * 4), 1'b1, 1'b0);
            if (i > 0) begin
                checks++; if (count !== 3'd1 || in_ready !== 1'b1) begin
                    errors++; $display("FAIL thru_count[%0d] got count=%0d rdy=%0b want 1/1", i, count, in_ready);
                end
                checks++; if (out_valid !== 1'b1 || out_pc !== mq[0].pc) begin
                    errors++; $display("FAIL thru_order[%0d] got pc=%h want %h", i, out_pc, mq[0].pc);
                end
            end
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (out_pc !== 32'h1000 + 32'(19 * 4)) begin
            errors++; $display("FAIL thru_last got pc=%h want %h", out_pc, 32'h1000 + 32'(19 * 4));
        end
        tick();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0000_0013, 32'h200 + 32'(i * 4), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h0000_0013, 32'h20C, 1'b0, 1'b1);
        checks++; if (count !== 3'd3 || in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_pre got count=%0d rdy=%0b want 3/0", count, in_ready);
        end
        tick();
        drive(1'b1, 32'h0000_0013, 32'h210, 1'b0, 1'b0);
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_empty got count=%0d v=%0b want 0/0", count, out_valid);
        end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h210 || count !== 3'd1) begin
            errors++; $display("FAIL flush_after got v=%0b pc=%h count=%0d want 1/210/1", out_valid, out_pc, count);
        end
        tick();
    endtask

    task automatic test_random();
        logic [6:0]  opcs [11];
        logic [31:0] r, ins;
        exp_t        e;
        opcs = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0010011,
                 7'b0110011, 7'b0110111, 7'b0010111, 7'b1110011, 7'b1011011};
        for (int c = 0; c < 300; c++) begin
            r   = $urandom();
            ins = {r[31:7], opcs[$urandom_range(0, 10)]};
            if (ins == 32'hFFFF_FFFF) ins[8] = 1'b0;
            drive($urandom_range(0, 3) != 0, ins, $urandom(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0);
            checks++; if (in_ready !== m_in_ready() || count !== 3'(mq.size())) begin
                errors++; $display("FAIL rnd_ctl[%0d] got rdy=%0b count=%0d want %0b/%0d", c, in_ready, count, m_in_ready(), mq.size());
            end
            if (mq.size() != 0) begin
                e = mq[0];
                checks++;
                if (out_valid !== 1'b1 || out_pc !== e.pc || out_instr !== e.instr || out_imm !== e.imm ||
                    out_opcode !== e.instr[6:0] || {out_rd, out_rs1, out_rs2} !== {e.rd, e.rs1, e.rs2} ||
                    {out_wen, out_dren, out_dwen, out_branch, out_jump, out_illegal, out_halt} !== e.flags) begin
                    errors++;
                    $display("FAIL rnd_head[%0d] got pc=%h ins=%h imm=%h fl=%b want pc=%h ins=%h imm=%h fl=%b", c,
                             out_pc, out_instr, out_imm,
                             {out_wen, out_dren, out_dwen, out_branch, out_jump, out_illegal, out_halt},
                             e.pc, e.instr, e.imm, e.flags);
                end
            end else begin
                checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0) begin
                    errors++; $display("FAIL rnd_empty[%0d] got v=%0b ins=%h want 0/0", c, out_valid, out_instr);
                end
            end
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_halt();
        drive(1'b1, 32'hFFFF_FFFF, 32'h100, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hFFC1_0093, 32'h104, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL halt_block got rdy=%0b want 0", in_ready); end
        tick();
        tick();
        drive(1'b1, 32'hFFC1_0093, 32'h104, 1'b1, 1'b0);
        checks++; if (out_halt !== 1'b1 || out_illegal !== 1'b0 || count !== 3'd1 || out_pc !== 32'h100) begin
            errors++; $display("FAIL halt_head got halt=%0b ill=%0b count=%0d pc=%h want 1/0/1/100", out_halt, out_illegal, count, out_pc);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (halted !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++; $display("FAIL halt_sticky[%0d] got h=%0b v=%0b rdy=%0b want 1/0/0", i, halted, out_valid, in_ready);
            end
            tick();
        end
        drive(1'b1, 32'hFFC1_0093, 32'h104, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flush got %0b want 1", halted); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        checks++; if (halted !== 1'b0 || in_ready !== 1'b1 || m_halted) begin
            errors++; $display("FAIL halt_rst got h=%0b rdy=%0b want 0/1", halted, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_decode();
        test_throughput();
        test_flush();
        test_random();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
